data_mem_responder: RTL and testbench

//  Responder end of the core's data-memory interface: accepts one load/store request at a time,

---
 rtl/data_mem_responder_pkg.sv | 22 ++
 rtl/data_mem_responder_mem_lane_align.sv | 41 ++++
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and checks for the data-memory responder
package data_mem_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;

   function automatic bit latency_ok(input int lat);
      return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
   endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// rtl/data_mem_responder_mem_lane_align.sv - store lane/byte-enable generation and load extraction
module mem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  st_lane,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_data,
   input  logic [1:0]  ld_lane,
   input  logic [1:0]  ld_size,
   input  logic        ld_unsigned,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shift;

   always_comb begin
      st_data = st_wdata << {st_lane, 3'b000};
      case (st_size)
         SZ_BYTE: st_be = 4'b0001 << st_lane;
         SZ_HALF: st_be = 4'b0011 << st_lane;
         SZ_WORD: st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      ld_shift = ld_word >> {ld_lane, 3'b000};
      case (ld_size)
         SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
         SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
         SZ_WORD: ld_data = ld_word;
         default: ld_data = 32'b0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder with fixed response latency
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);
   localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

   if (!latency_ok(LATENCY)) begin : g_latency_check
      $error("data_mem_responder: LATENCY must be within 1..15");
   end

   state_t      state, next_state;
   logic [3:0]  cnt;
   logic        ready_q;
   logic        accept;
   logic        req_err;
   logic [AW-1:0] widx;
   logic [31:0] mem [DEPTH_WORDS];

   logic        lat_write;
   logic        lat_err;
   logic        lat_unsigned;
   logic [1:0]  lat_lane;
   logic [1:0]  lat_size;
   logic [31:0] rd_word;

   logic [3:0]  st_be;
   logic [31:0] st_data;
   logic [31:0] ld_data;

   // reset gates accept so a store presented while reset is low never lands
   assign accept = req_valid && ready_q && reset;
   assign widx   = req_addr[AW+1:2];

   always_comb begin
      req_err = 1'b0;
      if (req_size == SZ_BAD)                              req_err = 1'b1;
      if ((req_size == SZ_HALF) && req_addr[0])            req_err = 1'b1;
      if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b0)) req_err = 1'b1;
      if (req_addr >= ADDR_LIMIT)                          req_err = 1'b1;
   end

   mem_lane_align u_align (
      .st_lane     (req_addr[1:0]),
      .st_size     (req_size),
      .st_wdata    (req_wdata),
      .st_be       (st_be),
      .st_data     (st_data),
      .ld_lane     (lat_lane),
      .ld_size     (lat_size),
      .ld_unsigned (lat_unsigned),
      .ld_word     (rd_word),
      .ld_data     (ld_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (accept)          next_state = ST_WAIT;
         ST_WAIT: if (cnt == 4'd0)     next_state = ST_RESP;
         ST_RESP: if (rsp_ready)       next_state = ST_IDLE;
         default:                      next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = ready_q;
      rsp_valid = (state == ST_RESP);
   end

   // array is intentionally outside reset: contents survive a reset pulse
   always_ff @(posedge clk) begin
      if (accept && req_write && !req_err) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ready_q      <= 1'b0;
         cnt          <= 4'd0;
         lat_write    <= 1'b0;
         lat_err      <= 1'b0;
         lat_unsigned <= 1'b0;
         lat_lane     <= 2'b0;
         lat_size     <= 2'b0;
         rd_word      <= 32'b0;
         rsp_rdata    <= 32'b0;
         rsp_err      <= 1'b0;
      end else begin
         ready_q <= (next_state == ST_IDLE);
         if (accept) begin
            cnt          <= CNT_LOAD;
            lat_write    <= req_write;
            lat_err      <= req_err;
            lat_unsigned <= req_unsigned;
            lat_lane     <= req_addr[1:0];
            lat_size     <= req_size;
            rd_word      <= mem[widx];
         end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if ((state == ST_WAIT) && (cnt == 4'd0)) begin
            rsp_rdata <= (lat_err || lat_write) ? 32'b0 : ld_data;
            rsp_err   <= lat_err;
         end else if ((state == ST_RESP) && rsp_ready) begin
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        req_valid, req_write, req_unsigned, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;

   logic        req_ready_a, rsp_valid_a, rsp_err_a;
   logic        req_ready_b, rsp_valid_b, rsp_err_b;
   logic [31:0] rsp_rdata_a, rsp_rdata_b;
   logic        req_valid_a, req_valid_b, rsp_ready_a, rsp_ready_b;
   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;

   assign req_valid_a = req_valid && !sel;
   assign req_valid_b = req_valid && sel;
   assign rsp_ready_a = rsp_ready && !sel;
   assign rsp_ready_b = rsp_ready && sel;
   assign o_req_ready = sel ? req_ready_b : req_ready_a;
   assign o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
   assign o_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
   assign o_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a),
      .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
   );

   data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
      .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
      .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   errors  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
      end
   endtask

   task automatic xact(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] sz, input logic u, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int hold,
                       input bit rst_mid);
      int   n;
      int   lat;
      exp_t e;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
      req_unsigned = u; req_wdata = wd;
      n = 0;
      while (o_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "/ready"}, 32'(o_req_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back('{rdata: er, err: ee});
      @(negedge clk);
      req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BAD;
      req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'b1;
      if (rst_mid) begin
         reset = 1'b0;
         @(negedge clk);
         reset = 1'b1;
         void'(exp_q.pop_front());
         lat = 0;
         repeat (6) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b0) lat++;
         end
         chk({tag, "/no_rsp"}, 32'(lat), 32'd0);
         return;
      end
      lat = 0;
      while (o_rsp_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "/lat"}, 32'(lat), sel ? 32'd1 : 32'd2);
      e = exp_q.pop_front();
      chk({tag, "/rdata"}, o_rsp_rdata, e.rdata);
      chk({tag, "/err"}, 32'(o_rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
            req_size = SZ_WORD; req_wdata = 32'hFFFF_FFFF;
         end
         @(negedge clk);
         chk({tag, "/hold_valid"}, 32'(o_rsp_valid), 32'd1);
         chk({tag, "/hold_rdata"}, o_rsp_rdata, e.rdata);
         chk({tag, "/hold_ready"}, 32'(o_req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "/done_valid"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, "/done_rdata"}, o_rsp_rdata, 32'd0);
      chk({tag, "/done_err"}, 32'(o_rsp_err), 32'd0);
      chk({tag, "/done_ready"}, 32'(o_req_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = 32'h0; req_size = SZ_WORD; req_unsigned = 1'b0;
      req_wdata = 32'h0; rsp_ready = 1'b0;

      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_ready", 32'(o_req_ready), 32'd0);
         chk("rst_valid", 32'(o_rsp_valid), 32'd0);
         chk("rst_rdata", o_rsp_rdata, 32'd0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(o_req_ready), 32'd1);
      chk("rel_valid", 32'(o_rsp_valid), 32'd0);

      xact("st_w10",  1, 32'h10, SZ_WORD, 0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
      xact("ld_w10",  0, 32'h10, SZ_WORD, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
      xact("ld_hu10", 0, 32'h10, SZ_HALF, 1, 32'h0, 32'h0000_BEEF, 0, 0, 0);
      xact("ld_hs12", 0, 32'h12, SZ_HALF, 0, 32'h0, 32'hFFFF_DEAD, 0, 0, 0);

      xact("st_w20",  1, 32'h20, SZ_WORD, 0, 32'h0, 32'h0, 0, 0, 0);
      xact("st_b21",  1, 32'h21, SZ_BYTE, 0, 32'h0000_0080, 32'h0, 0, 0, 0);
      xact("ld_bs21", 0, 32'h21, SZ_BYTE, 0, 32'h0, 32'hFFFF_FF80, 0, 0, 0);
      xact("ld_bu21", 0, 32'h21, SZ_BYTE, 1, 32'h0, 32'h0000_0080, 0, 0, 0);
      xact("ld_w20a", 0, 32'h20, SZ_WORD, 0, 32'h0, 32'h0000_8000, 0, 0, 0);
      xact("st_h22",  1, 32'h22, SZ_HALF, 0, 32'hAAAA_1234, 32'h0, 0, 0, 0);
      xact("ld_w20b", 0, 32'h20, SZ_WORD, 0, 32'h0, 32'h1234_8000, 0, 0, 0);
      xact("ld_hs22", 0, 32'h22, SZ_HALF, 0, 32'h0, 32'h0000_1234, 0, 0, 0);

      xact("err_h03",  0, 32'h03,  SZ_HALF, 0, 32'h0, 32'h0, 1, 0, 0);
      xact("err_w22",  0, 32'h22,  SZ_WORD, 0, 32'h0, 32'h0, 1, 0, 0);
      xact("err_sz",   0, 32'h20,  SZ_BAD,  0, 32'h0, 32'h0, 1, 0, 0);
      xact("err_rng",  0, 32'h400, SZ_WORD, 0, 32'h0, 32'h0, 1, 0, 0);
      xact("err_sth",  1, 32'h21,  SZ_HALF, 0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
      xact("err_stw",  1, 32'h400, SZ_WORD, 0, 32'hFFFF_FFFF, 32'h0, 1, 0, 0);
      xact("ld_w20c",  0, 32'h20,  SZ_WORD, 0, 32'h0, 32'h1234_8000, 0, 0, 0);

      xact("hold_ld",  0, 32'h10, SZ_WORD, 0, 32'h0, 32'hDEAD_BEEF, 0, 5, 0);
      xact("ld_w20d",  0, 32'h20, SZ_WORD, 0, 32'h0, 32'h1234_8000, 0, 0, 0);

      xact("rst_st30", 1, 32'h30, SZ_WORD, 0, 32'hCAFE_F00D, 32'h0, 0, 0, 1);
      xact("rst_ld10", 0, 32'h10, SZ_WORD, 0, 32'h0, 32'hDEAD_BEEF, 0, 0, 1);
      xact("ld_w30",   0, 32'h30, SZ_WORD, 0, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

      sel = 1'b1;
      xact("l1_st40",  1, 32'h40, SZ_WORD, 0, 32'h0BAD_F00D, 32'h0, 0, 0, 0);
      xact("l1_hu42",  0, 32'h42, SZ_HALF, 1, 32'h0, 32'h0000_0BAD, 0, 0, 0);
      xact("l1_bs40",  0, 32'h40, SZ_BYTE, 0, 32'h0, 32'h0000_000D, 0, 0, 0);
      xact("l1_err",   0, 32'h41, SZ_WORD, 0, 32'h0, 32'h0, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
